// File: rtl/fifo_sync_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_sync_rd_stream_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int SKID_DEPTH     = 2;

   typedef logic [1:0] occ_t;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_FILL,
      RD_STALL
   } rd_state_e;

endpackage

// File: rtl/fifo_sync_rd_stream_if.sv
// FIFO read port plus valid/ready output stream seen by the read adapter.
interface fifo_sync_rd_stream_if
   import fifo_sync_rd_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_rd_en;
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_ready;
   logic                  flush;

   modport master (
      input  fifo_empty, fifo_data, m_ready, flush,
      output fifo_rd_en, m_valid, m_data
   );

   modport slave (
      output fifo_empty, fifo_data, m_ready, flush,
      input  fifo_rd_en, m_valid, m_data
   );
endinterface

// File: rtl/fifo_sync_rd_stream_skid.sv
// Two-entry register buffer holding words returned by the FIFO until the consumer takes them.
module fifo_sync_rd_stream_skid
   import fifo_sync_rd_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   input  logic                  flush,
   output occ_t                  occ,
   output logic [DATA_WIDTH-1:0] head_data
);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
   logic                  head_q, head_d;
   logic                  tail_q, tail_d;
   occ_t                  occ_q, occ_d;

   always_comb begin
      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (flush) begin
         head_d = 1'b0;
         tail_d = 1'b0;
         occ_d  = '0;
      end else begin
         if (push) begin
            mem_d[tail_q] = push_data;
            tail_d        = ~tail_q;
         end
         if (pop) begin
            head_d = ~head_q;
         end
         occ_d = occ_q + occ_t'(push) - occ_t'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
         head_q <= 1'b0;
         tail_q <= 1'b0;
         occ_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign occ       = occ_q;
   assign head_data = mem_q[head_q];

   // The credit rule upstream must keep the buffer from ever overfilling.
   a_occ_max: assert property (@(posedge clk) disable iff (rst) occ_q <= occ_t'(SKID_DEPTH));

endmodule

// File: rtl/fifo_sync_rd_stream.sv
// Read-side adapter turning the synchronous FIFO read port into a valid/ready stream.
// Define FIFO_RD_STATS_EN to add the stat_words / stat_stalls saturating counters.
//
// state    | meaning
// RD_IDLE  | buffer empty, no read in flight
// RD_FILL  | read in flight and/or buffer partly filled (occ < 2)
// RD_STALL | buffer full (occ = 2), no new read until a pop
module fifo_sync_rd_stream
   import fifo_sync_rd_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   fifo_sync_rd_stream_if.master   bus
`ifdef FIFO_RD_STATS_EN
   ,
   output logic [31:0]             stat_words,
   output logic [31:0]             stat_stalls
`endif
);

   occ_t      occ;
   occ_t      occ_nx;
   logic      inflight_q, inflight_d;
   rd_state_e state_q, state_d;
   logic      pop;
   logic      push;
   logic      rd_en;
   logic [2:0] need;

   fifo_sync_rd_stream_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (bus.fifo_data),
      .pop       (pop),
      .flush     (bus.flush),
      .occ       (occ),
      .head_data (bus.m_data)
   );

   assign bus.m_valid = (occ != '0);
   assign pop         = bus.m_valid && bus.m_ready;
   assign push        = inflight_q;

   // Slots the buffer will hold after this edge if no new read is issued.
   assign need = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};

   always_comb begin
      rd_en = !rst && !bus.fifo_empty && !bus.flush
              && ((state_q != RD_STALL) || pop) && (need < 3'd2);
      inflight_d = rd_en;
      occ_nx     = occ + occ_t'(push) - occ_t'(pop);
      state_d    = RD_IDLE;
      if (!bus.flush) begin
         if (occ_nx == occ_t'(SKID_DEPTH))  state_d = RD_STALL;
         else if (rd_en || occ_nx != '0)    state_d = RD_FILL;
      end
   end

   assign bus.fifo_rd_en = rd_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= 1'b0;
         state_q    <= RD_IDLE;
      end else begin
         inflight_q <= inflight_d;
         state_q    <= state_d;
      end
   end

`ifdef FIFO_RD_STATS_EN
   logic [31:0] stat_words_q, stat_words_d;
   logic [31:0] stat_stalls_q, stat_stalls_d;

   always_comb begin
      stat_words_d  = stat_words_q;
      stat_stalls_d = stat_stalls_q;
      if (bus.flush) begin
         stat_words_d  = '0;
         stat_stalls_d = '0;
      end else begin
         if (pop && stat_words_q != '1) stat_words_d = stat_words_q + 32'd1;
         if (bus.m_valid && !bus.m_ready && stat_stalls_q != '1)
            stat_stalls_d = stat_stalls_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_words_q  <= '0;
         stat_stalls_q <= '0;
      end else begin
         stat_words_q  <= stat_words_d;
         stat_stalls_q <= stat_stalls_d;
      end
   end

   assign stat_words  = stat_words_q;
   assign stat_stalls = stat_stalls_q;
`endif

endmodule
